// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch buffer: streams sequential bus reads ahead of the core pc into a
// DEPTH-entry FIFO, serves sequential fetches combinationally and refetches on redirects.
module inst_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        inst_read_enable,
  output logic [31:0] inst_data,
  output logic        inst_wait_req,
  output logic        inst_valid,
  output logic [31:0] mem_address,
  output logic        mem_read_enable,
  input  logic [31:0] mem_read_data,
  input  logic        mem_wait_req,
  input  logic        mem_valid
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OccW = CntW + 1;

  logic [31:0]     fifo_q [DEPTH];
  logic [31:0]     fifo_d [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d, rd_idx;
  logic [CntW-1:0] count_q, count_d;
  logic [OccW-1:0] outstanding_q, outstanding_d;
  logic [OccW-1:0] discard_q, discard_d;
  logic [31:0]     stream_pc_q, stream_pc_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     mem_address_q, mem_address_d;
  logic            req_valid_q, req_valid_d;

  logic [31:0]     seq_pc;
  logic            hit, advance, advance_wait, empty_wait, redirect, pop;
  logic            accept, held, drop, write, load;
  logic [OccW-1:0] occupancy;

  assign seq_pc = stream_pc_q + 32'd4;

  always_comb begin
    hit          = 1'b0;
    advance      = 1'b0;
    advance_wait = 1'b0;
    empty_wait   = 1'b0;
    redirect     = 1'b0;
    if (inst_read_enable) begin
      if (count_q != '0 && pc == stream_pc_q)            hit          = 1'b1;
      else if (count_q >= CntW'(2) && pc == seq_pc)      advance      = 1'b1;
      else if (count_q == CntW'(1) && pc == seq_pc)      advance_wait = 1'b1;
      else if (count_q == '0 && pc == stream_pc_q)       empty_wait   = 1'b1;
      else                                               redirect     = 1'b1;
    end
  end

  assign pop           = advance | advance_wait;
  assign rd_idx        = advance ? head_q + PtrW'(1) : head_q;
  assign inst_data     = fifo_q[rd_idx];
  assign inst_valid    = hit | advance;
  assign inst_wait_req = advance_wait | empty_wait | redirect;

  assign accept = req_valid_q & ~mem_wait_req;
  assign held   = req_valid_q & mem_wait_req;
  assign drop   = mem_valid & (discard_q != '0);
  assign write  = mem_valid & ~drop & ~redirect;

  // Slots already promised: FIFO after this pop, plus every live read including the one in the
  // request register (accepted or not), since a new load only happens once that one moves on.
  assign occupancy = OccW'(count_q) - OccW'(pop) + outstanding_q + OccW'(req_valid_q) - discard_q;
  assign load      = (~req_valid_q | accept) & ~redirect & (occupancy < OccW'(DEPTH));

  always_comb begin
    fifo_d        = fifo_q;
    head_d        = head_q;
    tail_d        = tail_q;
    stream_pc_d   = stream_pc_q;
    fetch_pc_d    = fetch_pc_q;
    mem_address_d = mem_address_q;
    req_valid_d   = req_valid_q;
    count_d       = count_q - CntW'(pop) + CntW'(write);
    outstanding_d = outstanding_q + OccW'(accept) - OccW'(mem_valid);
    discard_d     = drop ? discard_q - OccW'(1) : discard_q;

    if (write) begin
      fifo_d[tail_q] = mem_read_data;
      tail_d         = tail_q + PtrW'(1);
    end
    if (pop) begin
      head_d      = head_q + PtrW'(1);
      stream_pc_d = seq_pc;
    end
    if (load) begin
      req_valid_d   = 1'b1;
      mem_address_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + 32'd4;
    end else if (accept) begin
      req_valid_d = 1'b0;
    end
    // Everything still on the bus, including a held request, now belongs to the old stream.
    if (redirect) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      stream_pc_d = pc;
      fetch_pc_d  = pc;
      discard_d   = outstanding_d + OccW'(held);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_q        <= '{default: '0};
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      stream_pc_q   <= RESET_PC;
      fetch_pc_q    <= RESET_PC;
      mem_address_q <= RESET_PC;
      req_valid_q   <= 1'b0;
    end else begin
      fifo_q        <= fifo_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      stream_pc_q   <= stream_pc_d;
      fetch_pc_q    <= fetch_pc_d;
      mem_address_q <= mem_address_d;
      req_valid_q   <= req_valid_d;
    end
  end

  assign mem_address     = mem_address_q;
  assign mem_read_enable = req_valid_q;

endmodule
